// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSQ and downstream memory signals around mem_port_arbiter.
// slave is the arbiter's view; master is the core/memory side that drives it.
interface mem_port_arbiter_if #(
  parameter int width = 32
);
  logic               i_mem_read;
  logic               i_mem_write;
  logic [width/8-1:0] i_mem_byte_enable;
  logic [width-1:0]   i_mem_address;
  logic [width-1:0]   i_mem_wdata;
  logic               i_mem_resp;
  logic [width-1:0]   i_mem_rdata;

  logic               lsq_mem_read;
  logic               lsq_mem_write;
  logic [width/8-1:0] lsq_mem_byte_enable;
  logic [width-1:0]   lsq_mem_address;
  logic [width-1:0]   lsq_mem_wdata;
  logic               lsq_mem_resp;
  logic [width-1:0]   lsq_mem_rdata;

  logic               mem_read;
  logic               mem_write;
  logic [width/8-1:0] mem_byte_enable;
  logic [width-1:0]   mem_address;
  logic [width-1:0]   mem_wdata;
  logic               mem_resp;
  logic [width-1:0]   mem_rdata;

  modport slave (
    input  i_mem_read, i_mem_write, i_mem_byte_enable, i_mem_address, i_mem_wdata,
    output i_mem_resp, i_mem_rdata,
    input  lsq_mem_read, lsq_mem_write, lsq_mem_byte_enable, lsq_mem_address, lsq_mem_wdata,
    output lsq_mem_resp, lsq_mem_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport master (
    output i_mem_read, i_mem_write, i_mem_byte_enable, i_mem_address, i_mem_wdata,
    input  i_mem_resp, i_mem_rdata,
    output lsq_mem_read, lsq_mem_write, lsq_mem_byte_enable, lsq_mem_address, lsq_mem_wdata,
    input  lsq_mem_resp, lsq_mem_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and LSQ requests onto one memory port, LSQ first by default.
// Define ARB_AGING_EN to let a starved fetch win after STARVE_LIMIT LSQ grants.
module mem_port_arbiter #(
  parameter int width        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int BW = width / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            state_q;
  logic              cmd_read_q;
  logic              cmd_write_q;
  logic [BW-1:0]     cmd_be_q;
  logic [width-1:0]  cmd_addr_q;
  logic [width-1:0]  cmd_wdata_q;

  logic fetch_pending;
  logic lsq_pending;
  logic pick_fetch;
  logic pick_lsq;
  logic starved;

`ifdef ARB_AGING_EN
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT);

  logic [AW-1:0] age_q;
  logic [AW-1:0] age_d;

  assign starved = (age_q == AGE_MAX);

  // Age counter next state: counts LSQ wins over a waiting fetch, saturating.
  always_comb begin
    age_d = age_q;
    if (pick_fetch) begin
      age_d = '0;
    end else if (pick_lsq) begin
      if (!fetch_pending) begin
        age_d = '0;
      end else if (!starved) begin
        age_d = age_q + AW'(1);
      end else begin
        age_d = age_q;
      end
    end else begin
      age_d = age_q;
    end
  end

  // Age counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  assign starved = 1'b0;
`endif

  // Grant decision, only meaningful while the port is free.
  always_comb begin
    fetch_pending = bus.i_mem_read | bus.i_mem_write;
    lsq_pending   = bus.lsq_mem_read | bus.lsq_mem_write;
    pick_fetch    = 1'b0;
    pick_lsq      = 1'b0;
    if (state_q == IDLE) begin
      if (fetch_pending && (!lsq_pending || starved)) begin
        pick_fetch = 1'b1;
      end else if (lsq_pending) begin
        pick_lsq = 1'b1;
      end else begin
        pick_fetch = 1'b0;
        pick_lsq   = 1'b0;
      end
    end else begin
      pick_fetch = 1'b0;
      pick_lsq   = 1'b0;
    end
  end

  // Grant FSM and command latch; the latch is the registered memory command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_be_q    <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_fetch) begin
            state_q     <= I_BUSY;
            cmd_read_q  <= bus.i_mem_read;
            cmd_write_q <= bus.i_mem_write;
            cmd_be_q    <= bus.i_mem_byte_enable;
            cmd_addr_q  <= bus.i_mem_address;
            cmd_wdata_q <= bus.i_mem_wdata;
          end else if (pick_lsq) begin
            state_q     <= D_BUSY;
            cmd_read_q  <= bus.lsq_mem_read;
            cmd_write_q <= bus.lsq_mem_write;
            cmd_be_q    <= bus.lsq_mem_byte_enable;
            cmd_addr_q  <= bus.lsq_mem_address;
            cmd_wdata_q <= bus.lsq_mem_wdata;
          end else begin
            state_q <= IDLE;
          end
        end
        I_BUSY, D_BUSY: begin
          if (bus.mem_resp) begin
            state_q     <= IDLE;
            cmd_read_q  <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_be_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_read_q  <= 1'b0;
          cmd_write_q <= 1'b0;
          cmd_be_q    <= '0;
          cmd_addr_q  <= '0;
          cmd_wdata_q <= '0;
        end
      endcase
    end
  end

  assign bus.mem_read        = cmd_read_q;
  assign bus.mem_write       = cmd_write_q;
  assign bus.mem_byte_enable = cmd_be_q;
  assign bus.mem_address     = cmd_addr_q;
  assign bus.mem_wdata       = cmd_wdata_q;

  // Completion is steered to the current owner only; a response in IDLE goes nowhere.
  assign bus.i_mem_resp    = (state_q == I_BUSY) && bus.mem_resp;
  assign bus.lsq_mem_resp  = (state_q == D_BUSY) && bus.mem_resp;
  assign bus.i_mem_rdata   = bus.i_mem_resp   ? bus.mem_rdata : '0;
  assign bus.lsq_mem_rdata = bus.lsq_mem_resp ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected transactions are queued
// when requests are driven and checked as the memory port carries them out.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;

  mem_port_arbiter_if #(.width(32)) bus ();

  mem_port_arbiter #(.width(32), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          owner;   // 0 = fetch, 1 = LSQ
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic own_resp(input bit o);
    return o ? bus.lsq_mem_resp : bus.i_mem_resp;
  endfunction

  function automatic logic oth_resp(input bit o);
    return o ? bus.i_mem_resp : bus.lsq_mem_resp;
  endfunction

  function automatic logic [31:0] own_rdata(input bit o);
    return o ? bus.lsq_mem_rdata : bus.i_mem_rdata;
  endfunction

  function automatic logic [31:0] oth_rdata(input bit o);
    return o ? bus.i_mem_rdata : bus.lsq_mem_rdata;
  endfunction

  task automatic clr_req(input bit o);
    if (o) begin
      bus.lsq_mem_read  = 1'b0;
      bus.lsq_mem_write = 1'b0;
    end else begin
      bus.i_mem_read  = 1'b0;
      bus.i_mem_write = 1'b0;
    end
  endtask

  task automatic push(input bit o, input logic rd, input logic wr, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    txn_t t;
    t.owner = o; t.rd = rd; t.wr = wr; t.be = be;
    t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    sb.push_back(t);
  endtask

  // Wait for the next grant, check it against the scoreboard head, hold for lat
  // cycles, respond, then confirm the port goes back to idle.
  task automatic serve(input int lat, input bit drop_early, input bit drop_after, output int waited);
    txn_t e;
    int   n = 0;
    while (!(bus.mem_read || bus.mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    chk("grant_seen", 32'(bus.mem_read | bus.mem_write), 32'd1);
    if (!(bus.mem_read || bus.mem_write)) return;
    chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("cmd_read",  32'(bus.mem_read),        32'(e.rd));
    chk("cmd_write", 32'(bus.mem_write),       32'(e.wr));
    chk("cmd_be",    32'(bus.mem_byte_enable), 32'(e.be));
    chk("cmd_addr",  bus.mem_address,          e.addr);
    chk("cmd_wdata", bus.mem_wdata,            e.wdata);
    if (drop_early) clr_req(e.owner);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("hold_addr",   bus.mem_address,    e.addr);
      chk("hold_read",   32'(bus.mem_read),  32'(e.rd));
      chk("hold_noresp", 32'(own_resp(e.owner)), 32'd0);
      chk("hold_rdata0", own_rdata(e.owner),     32'd0);
    end
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = e.rdata;
    #1;
    chk("owner_resp",   32'(own_resp(e.owner)), 32'd1);
    chk("owner_rdata",  own_rdata(e.owner),     e.rdata);
    chk("other_resp",   32'(oth_resp(e.owner)), 32'd0);
    chk("other_rdata",  oth_rdata(e.owner),     32'd0);
    @(negedge clk);
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'h5A5A_5A5A;
    if (drop_after) clr_req(e.owner);
    #1;
    chk("idle_after_resp", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("no_resp_idle",    32'({bus.i_mem_resp, bus.lsq_mem_resp}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bit order[$];
    bit drop;

    rst = 1'b0;
    bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; bus.i_mem_byte_enable = 4'h0;
    bus.i_mem_address = 32'h0; bus.i_mem_wdata = 32'h0;
    bus.lsq_mem_read = 1'b0; bus.lsq_mem_write = 1'b0; bus.lsq_mem_byte_enable = 4'h0;
    bus.lsq_mem_address = 32'h0; bus.lsq_mem_wdata = 32'h0;
    bus.mem_resp = 1'b0; bus.mem_rdata = 32'h5A5A_5A5A;

    repeat (2) @(negedge clk);
    chk("rst_cmd",   32'({bus.mem_read, bus.mem_write, bus.mem_byte_enable}), 32'd0);
    chk("rst_addr",  bus.mem_address, 32'd0);
    chk("rst_wdata", bus.mem_wdata,   32'd0);
    chk("rst_resp",  32'({bus.i_mem_resp, bus.lsq_mem_resp}), 32'd0);
    chk("rst_rdata", bus.i_mem_rdata | bus.lsq_mem_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch: command one cycle after the request, response two cycles later.
    bus.i_mem_read = 1'b1; bus.i_mem_address = 32'h60; bus.i_mem_byte_enable = 4'hF;
    push(1'b0, 1'b1, 1'b0, 4'hF, 32'h60, 32'h0, 32'h00A0_0093);
    serve(2, 1'b0, 1'b1, w);
    chk("fetch_grant_latency", 32'(w), 32'd1);

    // Collision: LSQ write first, fetch after one bubble.
    @(negedge clk);
    bus.i_mem_read = 1'b1; bus.i_mem_address = 32'h100; bus.i_mem_byte_enable = 4'hF;
    bus.lsq_mem_write = 1'b1; bus.lsq_mem_address = 32'h2000;
    bus.lsq_mem_wdata = 32'hDEAD_BEEF; bus.lsq_mem_byte_enable = 4'hF;
    push(1'b1, 1'b0, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 32'h0);
    push(1'b0, 1'b1, 1'b0, 4'hF, 32'h100,  32'h0,        32'h1111_2222);
    serve(1, 1'b0, 1'b1, w);
    chk("lsq_grant_latency", 32'(w), 32'd1);
    serve(1, 1'b0, 1'b1, w);
    chk("bubble_latency", 32'(w), 32'd1);

    // Starvation: fetch held pending while LSQ requests back to back.
`ifdef ARB_AGING_EN
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) order.push_back(1'b1);
      order.push_back(1'b0);
    end
    order.push_back(1'b1);
`else
    for (int k = 0; k < 20; k++) order.push_back(1'b1);
    order.push_back(1'b0);
`endif
    @(negedge clk);
    bus.lsq_mem_write = 1'b0;
    bus.i_mem_read = 1'b1; bus.i_mem_address = 32'h300; bus.i_mem_byte_enable = 4'hF;
    bus.lsq_mem_read = 1'b1; bus.lsq_mem_address = 32'h1000;
    bus.lsq_mem_wdata = 32'h0; bus.lsq_mem_byte_enable = 4'hF;
    for (int k = 0; k < order.size(); k++) begin
      push(order[k], 1'b1, 1'b0, 4'hF, order[k] ? 32'h1000 : 32'h300, 32'h0, 32'hC000_0000 + 32'(k));
      drop = 1'b1;
      for (int j = k + 1; j < order.size(); j++) if (order[j] == order[k]) drop = 1'b0;
      serve(0, 1'b0, drop, w);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Dropped request: LSQ deasserts right after the grant.
    @(negedge clk);
    bus.lsq_mem_read = 1'b1; bus.lsq_mem_address = 32'h40; bus.lsq_mem_byte_enable = 4'h3;
    push(1'b1, 1'b1, 1'b0, 4'h3, 32'h40, 32'h0, 32'h0BAD_F00D);
    serve(3, 1'b1, 1'b1, w);

    // Reset in the middle of an LSQ write.
    @(negedge clk);
    bus.lsq_mem_write = 1'b1; bus.lsq_mem_address = 32'h80;
    bus.lsq_mem_wdata = 32'h1234_5678; bus.lsq_mem_byte_enable = 4'hF;
    @(negedge clk);
    chk("pre_reset_write", 32'(bus.mem_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_cmd",   32'({bus.mem_read, bus.mem_write, bus.mem_byte_enable}), 32'd0);
    chk("midrst_addr",  bus.mem_address, 32'd0);
    chk("midrst_wdata", bus.mem_wdata,   32'd0);
    bus.lsq_mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    #1;
    chk("postrst_resp",  32'({bus.i_mem_resp, bus.lsq_mem_resp}), 32'd0);
    chk("postrst_rdata", bus.i_mem_rdata | bus.lsq_mem_rdata, 32'd0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    chk("postrst_idle", 32'({bus.mem_read, bus.mem_write}), 32'd0);

    // Stray response in IDLE, then a normal fetch to show the FSM is still idle.
    @(negedge clk);
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    #1;
    chk("stray_resp",  32'({bus.i_mem_resp, bus.lsq_mem_resp}), 32'd0);
    chk("stray_rdata", bus.i_mem_rdata | bus.lsq_mem_rdata, 32'd0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    #1;
    chk("stray_idle", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b1;
    bus.i_mem_address = 32'h500; bus.i_mem_wdata = 32'h7777_8888; bus.i_mem_byte_enable = 4'h5;
    push(1'b0, 1'b1, 1'b1, 4'h5, 32'h500, 32'h7777_8888, 32'h0000_ABCD);
    serve(1, 1'b0, 1'b1, w);
    chk("after_stray_latency", 32'(w), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
